// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder datapath stages.
// Holds widths, the normalizer state encoding and the packed result word.
package fp_pkg;

  localparam int MANT_W  = 23;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 2**EXP_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp_result_t;

endpackage

// File: rtl/fp_exp_adj.sv
// Exponent increment/decrement with saturation at the all-ones (inf) code.
// Arithmetic runs one bit wider so the increment carry-out is visible.
module fp_exp_adj
  import fp_pkg::*;
#(
  parameter int EXP_W = fp_pkg::EXP_W
) (
  input  logic [EXP_W-1:0] i_exp,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_hit_max,
  output logic             o_at_one
);

  localparam logic [EXP_W:0] LP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] LP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic [EXP_W:0] w_wide;
  logic [EXP_W:0] w_next;

  assign w_wide = {1'b0, i_exp};

  always_comb begin
    // NOTE: default first so no latch is inferred on the untaken paths
    w_next = w_wide;
    if (i_inc) begin
      w_next = w_wide + LP_ONE;
    end else if (i_dec && (i_exp != '0)) begin
      w_next = w_wide - LP_ONE;
    end
  end

  assign o_hit_max = i_inc && (w_next >= LP_MAX);
  assign o_exp     = o_hit_max ? LP_MAX[EXP_W-1:0] : w_next[EXP_W-1:0];
  assign o_at_one  = (i_exp == LP_ONE[EXP_W-1:0]);

endmodule

// File: rtl/fp_mant_normalizer.sv
// Post-add normalization: one right shift on carry, or iterative left shifts
// until the hidden bit is set or the exponent bottoms out as a denormal.
module fp_mant_normalizer
  import fp_pkg::*;
#(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W+1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_uflow,
  output logic              out_oflow
);

  norm_state_t       r_state;
  logic [MANT_W:0]   r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  logic              r_zero;
  logic              r_uflow;
  logic              r_oflow;
  logic              r_out_valid;

  logic [EXP_W-1:0]  w_adj_in;
  logic              w_inc;
  logic              w_dec;
  logic [EXP_W-1:0]  w_exp_next;
  logic              w_hit_max;
  logic              w_at_one;
  logic              w_carry;
  logic              w_mant_zero;

  assign w_carry     = in_mant[MANT_W+1];
  assign w_mant_zero = (in_mant == '0);

  // One adjuster serves both the accept-time increment and the NORM decrement.
  assign w_adj_in = (r_state == IDLE) ? in_exp : r_exp;
  assign w_inc    = (r_state == IDLE) && w_carry;
  assign w_dec    = (r_state == NORM) && !r_mant[MANT_W] && !w_at_one;

  fp_exp_adj #(.EXP_W(EXP_W)) u_exp_adj (
    .i_exp     (w_adj_in),
    .i_inc     (w_inc),
    .i_dec     (w_dec),
    .o_exp     (w_exp_next),
    .o_hit_max (w_hit_max),
    .o_at_one  (w_at_one)
  );

  // NOTE: non-blocking assignments so every branch sees pre-edge register values
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_uflow     <= 1'b0;
      r_oflow     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign  <= in_sign;
            r_zero  <= 1'b0;
            r_uflow <= 1'b0;
            r_oflow <= 1'b0;
            if (w_mant_zero) begin
              r_mant  <= '0;
              r_exp   <= '0;
              r_zero  <= 1'b1;
              r_state <= DONE;
            end else if (w_carry) begin
              r_exp   <= w_exp_next;
              r_state <= DONE;
              if (w_hit_max) begin
                r_mant  <= {1'b1, {MANT_W{1'b0}}};
                r_oflow <= 1'b1;
              end else begin
                r_mant <= in_mant[MANT_W+1:1];
              end
            end else if (in_exp == '0) begin
              r_mant  <= in_mant[MANT_W:0];
              r_exp   <= '0;
              r_state <= DONE;
            end else begin
              r_mant  <= in_mant[MANT_W:0];
              r_exp   <= in_exp;
              r_state <= NORM;
            end
          end
        end
        NORM: begin
          if (r_mant[MANT_W]) begin
            r_state <= DONE;
          end else if (w_at_one) begin
            // Stop shifting: exponent 0 marks the denormal encoding.
            r_exp   <= '0;
            r_uflow <= 1'b1;
            r_state <= DONE;
          end else begin
            r_mant <= {r_mant[MANT_W-1:0], 1'b0};
            r_exp  <= w_exp_next;
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_mant  = r_mant[MANT_W-1:0];
  assign out_exp   = r_exp;
  assign out_sign  = r_sign;
  assign out_zero  = r_zero;
  assign out_uflow = r_uflow;
  assign out_oflow = r_oflow;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Scoreboard bench for fp_mant_normalizer: the driver queues hand-computed
// results, a separate monitor compares them whenever a result is presented.
module tb_fp_mant_normalizer;
  import fp_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W+1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_sign;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic              out_zero;
  logic              out_uflow;
  logic              out_oflow;

  fp_mant_normalizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .out_oflow (out_oflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  ex;
    logic              sign;
    logic [2:0]        flags;  // {zero, uflow, oflow}
    int                lat;
    int                k;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every cycle a result is held, pops on handshake.
  initial begin : monitor
    logic prev_v;
    int   rise;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) rise = cyc;
          if (q.size() == 0) begin
            check("unexpected_valid", 64'(out_valid), 64'(0));
          end else begin
            check("in_ready_in_done", 64'(in_ready), 64'(0));
            check("mant", 64'(out_mant), 64'(q[0].mant));
            check("exp", 64'(out_exp), 64'(q[0].ex));
            check("sign", 64'(out_sign), 64'(q[0].sign));
            check("flags", 64'({out_zero, out_uflow, out_oflow}), 64'(q[0].flags));
            if (out_ready) begin
              check("latency", 64'(rise - q[0].k), 64'(q[0].lat));
              void'(q.pop_front());
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic send(input logic [MANT_W+1:0] m, input logic [EXP_W-1:0] e, input logic s,
                      input logic [MANT_W-1:0] xm, input logic [EXP_W-1:0] xe,
                      input logic [2:0] xf, input int lat, output int k);
    exp_t item;
    @(posedge clk) #1;
    in_mant  = m;
    in_exp   = e;
    in_sign  = s;
    in_valid = 1'b1;
    k = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        k = cyc + 1;
        break;
      end
    end
    if (k < 0) begin
      check("accept_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    item.mant  = xm;
    item.ex    = xe;
    item.sign  = s;
    item.flags = xf;
    item.lat   = lat;
    item.k     = k;
    q.push_back(item);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    check("drain_timeout", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    bit seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_outputs", 64'({out_mant, out_exp, out_sign, out_zero, out_uflow, out_oflow}), 64'(0));

    // Already normal, output held with out_ready low for 5 cycles.
    out_ready = 1'b0;
    send(25'h0800000, 8'h80, 1'b1, 23'h000000, 8'h80, 3'b000, 2, k);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("normal_valid_seen", 64'(seen), 64'(1));
    repeat (5) @(negedge clk);
    @(posedge clk) #1 out_ready = 1'b1;
    drain();

    send(25'h1800001, 8'h80, 1'b0, 23'h400000, 8'h81, 3'b000, 1, k);   // carry, LSB dropped
    drain();
    send(25'h0000001, 8'h80, 1'b0, 23'h000000, 8'h69, 3'b000, 25, k);  // max shift
    drain();

    // Max shift again, aborted by reset at accept+10.
    send(25'h0000001, 8'h80, 1'b0, 23'h000000, 8'h69, 3'b000, 25, k);
    while (cyc < k + 9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    q.delete();
    check("in_ready_after_reset", 64'(in_ready), 64'(1));
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t % 8 == 0) check("no_valid_after_reset", 64'(out_valid), 64'(0));
    end

    send(25'h0000100, 8'h03, 1'b1, 23'h000400, 8'h00, 3'b010, 4, k);   // underflow
    drain();
    send(25'h0000000, 8'h45, 1'b0, 23'h000000, 8'h00, 3'b100, 1, k);   // zero
    drain();
    send(25'h1000000, 8'hFE, 1'b0, 23'h000000, 8'hFF, 3'b001, 1, k);   // overflow
    drain();
    send(25'h0800000, 8'h01, 1'b0, 23'h000000, 8'h01, 3'b000, 2, k);   // hidden wins over exp==1
    drain();

    // Back-to-back, out_ready held high.
    send(25'h0400000, 8'h10, 1'b0, 23'h000000, 8'h0F, 3'b000, 3, k);
    send(25'h1FFFFFF, 8'h20, 1'b1, 23'h7FFFFF, 8'h21, 3'b000, 1, k);
    send(25'h0012345, 8'h90, 1'b0, 23'h11A280, 8'h89, 3'b000, 9, k);
    send(25'h0012345, 8'h00, 1'b1, 23'h012345, 8'h00, 3'b000, 1, k);   // already denormal
    send(25'h1FFFFFF, 8'hFF, 1'b0, 23'h000000, 8'hFF, 3'b001, 1, k);   // saturate at inf
    send(25'h0000000, 8'h00, 1'b1, 23'h000000, 8'h00, 3'b100, 1, k);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
